// File: rtl/riscv_dmem_arb.sv
// Two-port arbiter in front of riscv_dmem: port A is the core LSU (byte/half/word),
// port B is DMA/debug (word bursts of 1-16 beats). Responses are registered.
module riscv_dmem_arb #(
    parameter int XLEN          = 32,
    parameter int DMEM_ADDR_BIT = 12
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,
    input  logic                     i_a_req,
    input  logic                     i_a_wr,
    input  logic [DMEM_ADDR_BIT-1:0] i_a_addr,
    input  logic [1:0]               i_a_size,
    input  logic [XLEN-1:0]          i_a_wdata,
    output logic                     o_a_gnt,
    output logic                     o_a_rvalid,
    output logic [XLEN-1:0]          o_a_rdata,
    output logic                     o_a_err,
    input  logic                     i_b_req,
    input  logic                     i_b_wr,
    input  logic [DMEM_ADDR_BIT-1:0] i_b_addr,
    input  logic [3:0]               i_b_len,
    input  logic [XLEN-1:0]          i_b_wdata,
    output logic                     o_b_gnt,
    output logic                     o_b_beat,
    output logic                     o_b_rvalid,
    output logic [XLEN-1:0]          o_b_rdata,
    output logic                     o_b_done,
    output logic [DMEM_ADDR_BIT-3:0] o_dmem_addr,
    output logic [XLEN-1:0]          o_dmem_data,
    output logic [XLEN/8-1:0]        o_dmem_byte_sel,
    output logic                     o_dmem_wr_en,
    input  logic [XLEN-1:0]          i_dmem_data
);
    localparam int NB   = XLEN / 8;
    localparam int OFFW = $clog2(NB);
    localparam int WA   = DMEM_ADDR_BIT - 2;

    localparam logic S_IDLE  = 1'b0;
    localparam logic S_BURST = 1'b1;
    localparam logic PORT_A  = 1'b0;
    localparam logic PORT_B  = 1'b1;

    logic          state;
    logic          rr_last;
    logic [WA-1:0] b_addr_q;   // word address of the next burst beat
    logic [3:0]    b_cnt_q;    // beats remaining after the next one
    logic          b_wr_q;

    logic            a_win, b_win, burst_beat, beat, b_wr_cur, b_last;
    logic [OFFW-1:0] a_off;
    logic            a_mis;
    logic [NB-1:0]   a_sel;
    logic [XLEN-1:0] a_wdat, a_shift, a_load;
    logic            unused_b_addr_lsb;

    assign unused_b_addr_lsb = ^i_b_addr[1:0];

    // Nothing is granted while reset is held so an aborted burst cannot write.
    always_comb begin
        a_win      = (state == S_IDLE) && i_rstn && i_a_req && (!i_b_req || rr_last == PORT_B);
        b_win      = (state == S_IDLE) && i_rstn && i_b_req && !a_win;
        burst_beat = (state == S_BURST) && i_rstn;
        beat       = b_win || burst_beat;
        b_wr_cur   = b_win ? i_b_wr : b_wr_q;
        b_last     = b_win ? (i_b_len == 4'd0) : (b_cnt_q == 4'd0);
    end

    always_comb begin
        a_off   = i_a_addr[OFFW-1:0];
        a_shift = i_dmem_data >> {a_off, 3'b000};
        a_mis   = 1'b0;
        a_sel   = '0;
        a_wdat  = '0;
        a_load  = '0;
        case (i_a_size)
            2'b00: begin
                a_sel  = {{(NB-1){1'b0}}, 1'b1} << a_off;
                a_wdat = {NB{i_a_wdata[7:0]}};
                a_load = {{(XLEN-8){1'b0}}, a_shift[7:0]};
            end
            2'b01: begin
                a_mis  = a_off[0];
                a_sel  = {{(NB-2){1'b0}}, 2'b11} << a_off;
                a_wdat = {(NB/2){i_a_wdata[15:0]}};
                a_load = {{(XLEN-16){1'b0}}, a_shift[15:0]};
            end
            2'b10: begin
                a_mis  = (a_off != '0);
                a_sel  = '1;
                a_wdat = i_a_wdata;
                a_load = a_shift;
            end
            default: a_mis = 1'b1;
        endcase
    end

    always_comb begin
        o_dmem_addr     = '0;
        o_dmem_data     = '0;
        o_dmem_byte_sel = '0;
        o_dmem_wr_en    = 1'b0;
        if (a_win) begin
            o_dmem_addr     = i_a_addr[DMEM_ADDR_BIT-1:2];
            o_dmem_data     = a_wdat;
            o_dmem_byte_sel = a_sel;
            o_dmem_wr_en    = i_a_wr && !a_mis;
        end else if (b_win) begin
            o_dmem_addr     = i_b_addr[DMEM_ADDR_BIT-1:2];
            o_dmem_data     = i_b_wdata;
            o_dmem_byte_sel = '1;
            o_dmem_wr_en    = i_b_wr;
        end else if (burst_beat) begin
            o_dmem_addr     = b_addr_q;
            o_dmem_data     = i_b_wdata;
            o_dmem_byte_sel = '1;
            o_dmem_wr_en    = b_wr_q;
        end
    end

    assign o_a_gnt  = a_win;
    assign o_b_gnt  = b_win;
    assign o_b_beat = beat;

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state      <= S_IDLE;
            rr_last    <= PORT_B;
            b_addr_q   <= '0;
            b_cnt_q    <= '0;
            b_wr_q     <= 1'b0;
            o_a_rvalid <= 1'b0;
            o_a_err    <= 1'b0;
            o_a_rdata  <= '0;
            o_b_rvalid <= 1'b0;
            o_b_rdata  <= '0;
            o_b_done   <= 1'b0;
        end else begin
            o_a_rvalid <= a_win;
            o_a_err    <= a_win && a_mis;
            o_a_rdata  <= (a_win && !i_a_wr && !a_mis) ? a_load : '0;
            o_b_rvalid <= beat && !b_wr_cur;
            o_b_rdata  <= (beat && !b_wr_cur) ? i_dmem_data : '0;
            o_b_done   <= beat && b_last;
            if (a_win) begin
                rr_last <= PORT_A;
            end else if (b_win) begin
                rr_last  <= PORT_B;
                b_wr_q   <= i_b_wr;
                b_addr_q <= i_b_addr[DMEM_ADDR_BIT-1:2] + 1'b1;
                b_cnt_q  <= i_b_len - 4'd1;
                if (i_b_len != 4'd0) state <= S_BURST;
            end else if (burst_beat) begin
                b_addr_q <= b_addr_q + 1'b1;
                if (b_cnt_q == 4'd0) state <= S_IDLE;
                else                 b_cnt_q <= b_cnt_q - 4'd1;
            end
        end
    end
endmodule

// File: doc/riscv_dmem_arb.md
Name: riscv_dmem_arb

Overview:
- Two-port arbiter/controller in front of riscv_dmem (word-addressed, byte-select write, combinational read, write on rising i_clk).
- Port A: core LSU, single-beat byte/half/word accesses with lane alignment.
- Port B: DMA/debug, word bursts of 1–16 beats with an auto-incrementing address.
- Arbitrates per transaction and registers the read response (1-cycle latency).

Parameters:
- XLEN, 32, data width; byte lanes = XLEN/8 = 4.
- DMEM_ADDR_BIT, 12, byte-address width; memory word address = DMEM_ADDR_BIT-2 bits.

Ports:
- i_clk  in  1  clock, rising edge
- i_rstn  in  1  synchronous active-low reset
- i_a_req  in  1  core request
- i_a_wr  in  1  1 = store, 0 = load
- i_a_addr  in  DMEM_ADDR_BIT  byte address
- i_a_size  in  2  00 = byte, 01 = half, 10 = word, 11 = reserved
- i_a_wdata  in  XLEN  store data, right-justified
- o_a_gnt  out  1  request accepted this cycle (combinational)
- o_a_rvalid  out  1  response valid (registered)
- o_a_rdata  out  XLEN  load data, right-justified, zero-extended
- o_a_err  out  1  misaligned or reserved size; pulses with o_a_rvalid
- i_b_req  in  1  DMA burst request
- i_b_wr  in  1  burst direction
- i_b_addr  in  DMEM_ADDR_BIT  start byte address; bits [1:0] ignored
- i_b_len  in  4  beats minus 1
- i_b_wdata  in  XLEN  write data, sampled on every o_b_beat cycle
- o_b_gnt  out  1  burst accepted (1-cycle pulse; first beat executes the same cycle)
- o_b_beat  out  1  a beat executes this cycle
- o_b_rvalid  out  1  read beat data valid (registered)
- o_b_rdata  out  XLEN  read beat data
- o_b_done  out  1  pulses the cycle after the last beat
- o_dmem_addr  out  DMEM_ADDR_BIT-2  memory word address
- o_dmem_data  out  XLEN  memory write data
- o_dmem_byte_sel  out  XLEN/8  memory byte lanes
- o_dmem_wr_en  out  1  memory write enable
- i_dmem_data  in  XLEN  memory read data (combinational)

Behaviour:
- Reset (i_rstn=0 at an edge): state IDLE, rr_last=B (A favoured next), beat and address counters cleared, all registered outputs 0. Reset during a burst aborts it: no further beats, no o_b_done.
- Memory-side outputs are combinational from state and the granted port. When nothing is granted, o_dmem_wr_en=0, byte_sel=0, addr=0, data=0.
- State IDLE:
  - Only A requests -> grant A.
  - Only B requests -> grant B.
  - Both request -> grant the port opposite rr_last.
  - rr_last updates to the granted port.
- Grant B: o_b_gnt=1, o_b_beat=1, beat 0 executes at the word address i_b_addr[DMEM_ADDR_BIT-1:2]; i_b_wr and i_b_len are latched. If len=0, stay in IDLE; otherwise go to BURST.
- State BURST:
  - One beat per cycle, o_b_beat=1; o_a_gnt=0; non-preemptible.
  - Word address increments by 1 and wraps modulo 2^(DMEM_ADDR_BIT-2).
  - Byte_sel is always 1111.
  - After beat len, return to IDLE. rr_last=B, so A wins the next cycle if it is requesting.
- Port B response:
  - For reads, o_b_rvalid/o_b_rdata appear 1 cycle after each beat.
  - o_b_done pulses 1 cycle after the last beat for both reads and writes.
- Port A accesses execute in the grant cycle.
- Alignment rules:
  - Byte: byte_sel = 0001 << addr[1:0]; data = {4{wdata[7:0]}}.
  - Half: byte_sel = 0011 << addr[1:0]; data = {2{wdata[15:0]}}; addr[0] must be 0.
  - Word: byte_sel = 1111; addr[1:0] must be 00.
- Misaligned access or size 11: still granted, but o_dmem_wr_en is forced to 0. The next cycle gives o_a_rvalid=1, o_a_err=1, o_a_rdata=0.
- Port A response: o_a_rvalid pulses 1 cycle after every grant, loads and stores alike.
- Load data: (i_dmem_data >> 8*addr[1:0]) masked to 8/16/32 bits, zero-extended. Offset and size are registered with the data. Sign extension is done by the core.
- A write is visible to a read issued in the following cycle (read-after-write).
- Requesters hold their request until the grant. A request dropped without a grant is never executed.

Test Plan:
- Reset then idle for 4 cycles -> all outputs 0 and o_dmem_wr_en never asserts.
- A: store word 0x11223344 to 0x010, then load word 0x010 -> load has o_a_rvalid 1 cycle after o_a_gnt, rdata=0x11223344. Then store byte 0xAB to 0x012 -> byte_sel=0100; load word 0x010 returns 0x11AB3344.
- A: load half from 0x012 after the above -> 0x000011AB. Store half to 0x011 -> o_dmem_wr_en=0; o_a_err=1 and o_a_rvalid=1 next cycle; memory word unchanged.
- B: write burst addr 0x000, len 3, data 0..3 -> o_b_beat for 4 consecutive cycles; o_b_done 1 cycle later. Then read burst len 3 -> o_b_rdata 0,1,2,3 on 4 consecutive o_b_rvalid.
- Contention: A and B both request from reset -> A granted first. B's len-7 burst then runs 8 beats while A waits. A is granted the cycle after the last beat, and B's re-request waits 1 cycle.
- Wrap: B burst starting at the top word, len 1 -> beats at word addresses 2^(DMEM_ADDR_BIT-2)-1 then 0. Reset asserted after beat 2 of a len-7 write burst -> no further writes, no o_b_done, state IDLE.
